noc_step_sequencer: RTL and testbench
=====================================

Name: noc_step_sequencer

Overview:
- Central controller that sequences NUM_ROUTERS router instances in lock-step by broadcasting a shared op/data/in_cycle bus.
- Runs the network bring-up: Init, then streaming routing-table entries via LoadRt.
- Then repeats the per-cycle sequence LoadStaging -> Phase0 -> Phase1 and advances in_cycle.
- Detects network quiescence from the routers' done outputs, or stops at a cycle budget, and reports completion to the testbench/top.

Parameters:
- NUM_ROUTERS, 4, number of routers whose done outputs are ANDed.
- OP_W, 3, width of op bus; must equal `op_size.
- DATA_W, 32, width of data bus; must equal `DataBitSize.
- CYCLE_W, 16, width of in_cycle and cycle counters; must equal `in_cycle_size.
- DRAIN_CYCLES, 2, consecutive quiet network cycles required before finishing (1..15).

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: one-cycle pulse; accepted only in IDLE.
- cfg_credit_delay, input, 12: credit delay placed on data during Init (data[11:0]; other bits 0).
- max_cycles, input, CYCLE_W: cycle budget. 0 = unlimited.
- rt_valid, input, 1: routing entry available.
- rt_data, input, DATA_W: routing entry, passed unchanged to data.
- rt_last, input, 1: marks the final routing entry.
- rt_ready, output, 1: entry consumed this cycle (valid & ready transfer).
- router_done, input, NUM_ROUTERS: done outputs of all routers.
- op, output, OP_W: broadcast opcode (`NOP/`Init/`LoadRt/`LoadStaging/`Phase0/`Phase1).
- data, output, DATA_W: broadcast data.
- in_cycle, output, CYCLE_W: current network cycle.
- busy, output, 1: high in any state other than IDLE/FINISH.
- finished, output, 1: high in FINISH.
- timeout, output, 1: finish was caused by max_cycles; sticky until the next start.

Behaviour:
- Reset (async on rst_n low): state = IDLE; op = `NOP; data = 0; in_cycle = 0; rt_ready = 0; busy = 0; finished = 0; timeout = 0; quiet_cnt = 0. All outputs are registered.
- States: IDLE, INIT, LOAD_RT, LOAD_STG, PH0, PH1, CHECK, FINISH. op is driven for exactly the cycle the FSM is in the matching state; every other state drives `NOP.
- IDLE: on start go to INIT; clear in_cycle, quiet_cnt and timeout.
- INIT: op = `Init, data = {0, cfg_credit_delay}. Next state LOAD_RT.
- LOAD_RT:
  - rt_ready = 1. If rt_valid, op = `LoadRt and data = rt_data; otherwise op = `NOP (stall, no timeout).
  - On a transfer with rt_last, go to LOAD_STG.
  - rt_ready is a registered-combinational equivalent: it is asserted only while in LOAD_RT.
- LOAD_STG: op = `LoadStaging -> PH0.
- PH0: op = `Phase0 -> PH1.
- PH1:
  - op = `Phase0 result is now visible on router_done; capture q0 = &router_done.
  - op = `Phase1 -> CHECK.
- CHECK:
  - op = `NOP. Capture q1 = &router_done, which is the Phase1 result.
  - quiet = q0 & q1. If quiet, quiet_cnt++ (saturating at 15); otherwise quiet_cnt = 0.
  - Then evaluate in priority order:
    1. quiet_cnt (after update) == DRAIN_CYCLES -> FINISH, timeout = 0.
    2. max_cycles != 0 and in_cycle + 1 == max_cycles -> FINISH, timeout = 1.
    3. Otherwise in_cycle++ (wraps modulo 2^CYCLE_W when max_cycles = 0) -> LOAD_STG.
- in_cycle is stable from LOAD_STG through CHECK of the same network cycle. One network cycle = 4 clocks.
- FINISH: finished = 1; holds in_cycle. A start pulse returns to INIT (full restart). Otherwise stays.
- start outside IDLE/FINISH is ignored.
- Reset mid-operation: immediate return to IDLE values; the next op is `NOP.

Optional Feature:
- Macro SEQ_STEP_MODE_EN.
- When defined: adds input step_req (1 bit) and state HOLD. CHECK transitions that would go to LOAD_STG go to HOLD instead. HOLD drives op = `NOP and waits for a step_req pulse, then goes to LOAD_STG. FINISH decisions are unchanged. busy stays high in HOLD.
- When undefined: no step_req port, no HOLD state; CHECK goes directly to LOAD_STG.

Test Plan:
- Reset/idle: assert rst_n=0 mid-PH0, release -> op=`NOP, in_cycle=0, busy=0, finished=0; no op issued until start.
- Bring-up: cfg_credit_delay=5, three rt entries, rt_valid gapped by 2 idle clocks before the 2nd -> ops Init(data=5), LoadRt x3 with exact rt_data, `NOP during gaps, then LoadStaging.
- Quiescence: router_done all 1s from the start, DRAIN_CYCLES=2 -> finished after network cycle 1 (in_cycle=1), timeout=0, total 2 LoadStaging ops.
- Partial done: router_done=4'b1011 for cycles 0..9, then 4'b1111 -> quiet_cnt stays 0 until cycle 10; finishes at in_cycle=11.
- Budget: router_done=0 always, max_cycles=8 -> finished with timeout=1, in_cycle=7, exactly 8 Phase1 ops.
- Step mode (SEQ_STEP_MODE_EN): no step_req -> op stays `NOP in HOLD after CHECK; each pulse advances exactly one network cycle (in_cycle +1).

Source files
------------

// File: rtl/noc_step_sequencer_if.sv
// Sequencer bus bundle: routing-table stream in, lock-step broadcast bus out.
// The sequencer connects through the master modport, a router/bench through slave.
interface noc_step_sequencer_if #(
  parameter int OP_W    = 3,
  parameter int DATA_W  = 32,
  parameter int CYCLE_W = 16
);
  logic              rt_valid;
  logic [DATA_W-1:0] rt_data;
  logic              rt_last;
  logic              rt_ready;
  logic [OP_W-1:0]   op;
  logic [DATA_W-1:0] data;
  logic [CYCLE_W-1:0] in_cycle;

  modport master (
    input  rt_valid, rt_data, rt_last,
    output rt_ready, op, data, in_cycle
  );

  modport slave (
    output rt_valid, rt_data, rt_last,
    input  rt_ready, op, data, in_cycle
  );
endinterface

// File: rtl/noc_step_sequencer.sv
// Lock-step NoC controller: Init, routing-table load, then LoadStaging/Phase0/Phase1
// per network cycle until quiescence or cycle budget. SEQ_STEP_MODE_EN adds single-step HOLD.
module noc_step_sequencer #(
  parameter int NUM_ROUTERS  = 4,
  parameter int OP_W         = 3,
  parameter int DATA_W       = 32,
  parameter int CYCLE_W      = 16,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [11:0]            cfg_credit_delay_i,
  input  logic [CYCLE_W-1:0]     max_cycles_i,
  input  logic [NUM_ROUTERS-1:0] router_done_i,
`ifdef SEQ_STEP_MODE_EN
  input  logic                   step_req_i,
`endif
  noc_step_sequencer_if.master   bus,
  output logic                   busy_o,
  output logic                   finished_o,
  output logic                   timeout_o
);

  localparam logic [OP_W-1:0] OP_NOP     = OP_W'(0);
  localparam logic [OP_W-1:0] OP_INIT    = OP_W'(1);
  localparam logic [OP_W-1:0] OP_LOAD_RT = OP_W'(2);
  localparam logic [OP_W-1:0] OP_LOAD_ST = OP_W'(3);
  localparam logic [OP_W-1:0] OP_PHASE0  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_PHASE1  = OP_W'(5);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_LOAD_RT, S_LOAD_STG, S_PH0, S_PH1, S_CHECK, S_FINISH
`ifdef SEQ_STEP_MODE_EN
    , S_HOLD
`endif
  } state_e;

  state_e             state_q, state_d;
  logic [CYCLE_W-1:0] in_cycle_q, in_cycle_d;
  logic [3:0]         quiet_cnt_q, quiet_cnt_d;
  logic               q0_q, q0_d;
  logic               timeout_q, timeout_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               rt_ready_q, rt_ready_d;
  logic               busy_q, busy_d;
  logic               finished_q, finished_d;
  logic               all_done;

  assign all_done = &router_done_i;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    in_cycle_d  = in_cycle_q;
    quiet_cnt_d = quiet_cnt_q;
    q0_d        = q0_q;
    timeout_d   = timeout_q;

    unique case (state_q)
      S_IDLE, S_FINISH: begin
        if (start_i) begin
          state_d     = S_INIT;
          in_cycle_d  = '0;
          quiet_cnt_d = '0;
          timeout_d   = 1'b0;
        end
      end
      S_INIT:     state_d = S_LOAD_RT;
      S_LOAD_RT:  if (bus.rt_valid && bus.rt_last) state_d = S_LOAD_STG;
      S_LOAD_STG: state_d = S_PH0;
      S_PH0:      state_d = S_PH1;
      S_PH1: begin
        q0_d    = all_done;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (q0_q && all_done) quiet_cnt_d = (quiet_cnt_q == 4'd15) ? 4'd15 : quiet_cnt_q + 4'd1;
        else                  quiet_cnt_d = '0;
        if (quiet_cnt_d == 4'(DRAIN_CYCLES)) begin
          state_d   = S_FINISH;
          timeout_d = 1'b0;
        end else if (max_cycles_i != '0 && CYCLE_W'(in_cycle_q + 1'b1) == max_cycles_i) begin
          state_d   = S_FINISH;
          timeout_d = 1'b1;
        end else begin
          in_cycle_d = in_cycle_q + 1'b1;
`ifdef SEQ_STEP_MODE_EN
          state_d    = S_HOLD;
`else
          state_d    = S_LOAD_STG;
`endif
        end
      end
`ifdef SEQ_STEP_MODE_EN
      S_HOLD: if (step_req_i) state_d = S_LOAD_STG;
`endif
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they appear registered in that state.
    op_d   = OP_NOP;
    data_d = '0;
    unique case (state_d)
      S_INIT: begin
        op_d   = OP_INIT;
        data_d = DATA_W'(cfg_credit_delay_i);
      end
      S_LOAD_STG: op_d = OP_LOAD_ST;
      S_PH0:      op_d = OP_PHASE0;
      S_PH1:      op_d = OP_PHASE1;
      default:    op_d = OP_NOP;
    endcase
    rt_ready_d = (state_d == S_LOAD_RT);
    busy_d     = !(state_d inside {S_IDLE, S_FINISH});
    finished_d = (state_d == S_FINISH);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_cycle_q  <= '0;
      quiet_cnt_q <= '0;
      q0_q        <= 1'b0;
      timeout_q   <= 1'b0;
      op_q        <= OP_NOP;
      data_q      <= '0;
      rt_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      finished_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_cycle_q  <= in_cycle_d;
      quiet_cnt_q <= quiet_cnt_d;
      q0_q        <= q0_d;
      timeout_q   <= timeout_d;
      op_q        <= op_d;
      data_q      <= data_d;
      rt_ready_q  <= rt_ready_d;
      busy_q      <= busy_d;
      finished_q  <= finished_d;
    end
  end

  // A routing entry must reach the routers in the cycle it transfers, so LOAD_RT bypasses op_q/data_q.
  assign bus.op       = rt_ready_q ? (bus.rt_valid ? OP_LOAD_RT : OP_NOP) : op_q;
  assign bus.data     = (rt_ready_q && bus.rt_valid) ? bus.rt_data : data_q;
  assign bus.rt_ready = rt_ready_q;
  assign bus.in_cycle = in_cycle_q;
  assign busy_o       = busy_q;
  assign finished_o   = finished_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_noc_step_sequencer.sv
// Scoreboard bench for noc_step_sequencer: expected broadcast ops are queued per run
// and popped by a monitor whenever the DUT issues a non-NOP op.
module tb_noc_step_sequencer;

  localparam logic [2:0] OP_NOP = 3'd0, OP_INIT = 3'd1, OP_LOAD_RT = 3'd2;
  localparam logic [2:0] OP_LOAD_ST = 3'd3, OP_PHASE0 = 3'd4, OP_PHASE1 = 3'd5;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] data;
    bit          chk_data;
    logic [15:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        step_req = 1'b0;
  logic [11:0] cfg_cd = 12'd0;
  logic [15:0] max_cycles = 16'd0;
  logic [3:0]  done_const = 4'h0;
  bit          partial_mode = 1'b0;
  logic [3:0]  router_done;
  logic        busy, finished, timeout;

  int   checks = 0;
  int   errors = 0;
  int   ph1_cnt = 0;
  int   stg_cnt = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [31:0] rt_vec [3];

  noc_step_sequencer_if #(.OP_W(3), .DATA_W(32), .CYCLE_W(16)) bus ();

  noc_step_sequencer #(
    .NUM_ROUTERS(4), .OP_W(3), .DATA_W(32), .CYCLE_W(16), .DRAIN_CYCLES(2)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start_i            (start),
    .cfg_credit_delay_i (cfg_cd),
    .max_cycles_i       (max_cycles),
    .router_done_i      (router_done),
`ifdef SEQ_STEP_MODE_EN
    .step_req_i         (step_req),
`endif
    .bus                (bus.master),
    .busy_o             (busy),
    .finished_o         (finished),
    .timeout_o          (timeout)
  );

  always #5 clk = ~clk;

  // Partial scenario: one router stays busy until network cycle 10.
  assign router_done = partial_mode ? ((bus.in_cycle >= 16'd10) ? 4'b1111 : 4'b1011) : done_const;

  always @(negedge clk) begin
    if (rst_n && bus.op !== OP_NOP) begin
      if (bus.op === OP_PHASE1) ph1_cnt = ph1_cnt + 1;
      if (bus.op === OP_LOAD_ST) stg_cnt = stg_cnt + 1;
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_op got op=%0d in_cycle=%0d required none", bus.op, bus.in_cycle);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.op !== mon_e.op || bus.in_cycle !== mon_e.cyc ||
            (mon_e.chk_data && bus.data !== mon_e.data)) begin
          errors = errors + 1;
          $display("FAIL sb_op got op=%0d data=%h cyc=%0d required op=%0d data=%h cyc=%0d",
                   bus.op, bus.data, bus.in_cycle, mon_e.op, mon_e.data, mon_e.cyc);
        end
      end
    end
  end

  task automatic push_run(input logic [11:0] cd, input int n_rt, input int n_cyc);
    exp_t e;
    e = '{OP_INIT, {20'd0, cd}, 1'b1, 16'd0};
    exp_q.push_back(e);
    for (int i = 0; i < n_rt; i++) begin
      e = '{OP_LOAD_RT, rt_vec[i], 1'b1, 16'd0};
      exp_q.push_back(e);
    end
    for (int c = 0; c < n_cyc; c++) begin
      e = '{OP_LOAD_ST, 32'd0, 1'b0, 16'(c)}; exp_q.push_back(e);
      e = '{OP_PHASE0,  32'd0, 1'b0, 16'(c)}; exp_q.push_back(e);
      e = '{OP_PHASE1,  32'd0, 1'b0, 16'(c)}; exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send_rt(input logic [31:0] d, input logic last);
    int n = 0;
    bus.rt_valid = 1'b1;
    bus.rt_data  = d;
    bus.rt_last  = last;
    while (!bus.rt_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.rt_ready) begin
      checks = checks + 1; errors = errors + 1;
      $display("FAIL rt_ready_wait got rt_ready=0 required 1 within 50 clocks");
    end
    @(posedge clk); #1;
    bus.rt_valid = 1'b0;
    bus.rt_last  = 1'b0;
  endtask

  task automatic wait_finished(input int budget);
    int n = 0;
    while (!finished && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checks = checks + 1;
    if (finished !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL finish_wait got finished=%b required 1 within %0d clocks", finished, budget);
    end
  endtask

  task automatic check_end(input string name, input logic exp_to, input logic [15:0] exp_cyc,
                           input int exp_ph1, input int exp_stg);
    @(negedge clk);
    checks = checks + 1;
    if (busy !== 1'b0 || timeout !== exp_to || bus.in_cycle !== exp_cyc) begin
      errors = errors + 1;
      $display("FAIL %s_end got busy=%b timeout=%b in_cycle=%0d required busy=0 timeout=%b in_cycle=%0d",
               name, busy, timeout, bus.in_cycle, exp_to, exp_cyc);
    end
    checks = checks + 1;
    if (ph1_cnt != exp_ph1 || stg_cnt != exp_stg) begin
      errors = errors + 1;
      $display("FAIL %s_counts got ph1=%0d stg=%0d required ph1=%0d stg=%0d",
               name, ph1_cnt, stg_cnt, exp_ph1, exp_stg);
    end
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL %s_leftover got %0d pending ops required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    int n = 0;
    #1;
    checks = checks + 1;
    if (bus.op !== OP_NOP || bus.in_cycle !== 16'd0 || busy !== 1'b0 || finished !== 1'b0 ||
        timeout !== 1'b0 || bus.rt_ready !== 1'b0 || bus.data !== 32'd0) begin
      errors = errors + 1;
      $display("FAIL por_values got op=%0d cyc=%0d busy=%b fin=%b to=%b rdy=%b required all zero",
               bus.op, bus.in_cycle, busy, finished, timeout, bus.rt_ready);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    done_const = 4'h0; max_cycles = 16'd0; cfg_cd = 12'h2A;
    rt_vec[0] = 32'hCAFE_0001;
    push_run(cfg_cd, 1, 0);
    exp_q.push_back('{OP_LOAD_ST, 32'd0, 1'b0, 16'd0});
    exp_q.push_back('{OP_PHASE0,  32'd0, 1'b0, 16'd0});
    pulse_start();
    send_rt(rt_vec[0], 1'b1);
    while (bus.op !== OP_PHASE0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    #2 rst_n = 1'b0;
    #1;
    checks = checks + 1;
    if (bus.op !== OP_NOP || bus.in_cycle !== 16'd0 || busy !== 1'b0 || finished !== 1'b0 ||
        bus.rt_ready !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL mid_reset got op=%0d cyc=%0d busy=%b fin=%b rdy=%b required NOP/0/0/0/0",
               bus.op, bus.in_cycle, busy, finished, bus.rt_ready);
    end
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL reset_prefix got %0d pending ops required 0", exp_q.size());
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checks = checks + 1;
      if (bus.op !== OP_NOP || busy !== 1'b0) begin
        errors = errors + 1;
        $display("FAIL post_reset_idle got op=%0d busy=%b required op=0 busy=0", bus.op, busy);
      end
    end
  endtask

  task automatic test_bringup_quiesce();
    cfg_cd = 12'd5; done_const = 4'hF; max_cycles = 16'd0;
    rt_vec[0] = 32'h1111_0000; rt_vec[1] = 32'hA5A5_5A5A; rt_vec[2] = 32'hDEAD_BEEF;
    ph1_cnt = 0; stg_cnt = 0;
    push_run(cfg_cd, 3, 2);
    pulse_start();
    send_rt(rt_vec[0], 1'b0);
    repeat (2) begin
      @(negedge clk);
      checks = checks + 1;
      if (bus.op !== OP_NOP || bus.rt_ready !== 1'b1) begin
        errors = errors + 1;
        $display("FAIL rt_gap got op=%0d rt_ready=%b required op=0 rt_ready=1", bus.op, bus.rt_ready);
      end
      @(posedge clk); #1;
    end
    send_rt(rt_vec[1], 1'b0);
    send_rt(rt_vec[2], 1'b1);
    wait_finished(200);
    check_end("quiesce", 1'b0, 16'd1, 2, 2);
  endtask

  task automatic test_partial_done();
    partial_mode = 1'b1; max_cycles = 16'd0; cfg_cd = 12'd7;
    rt_vec[0] = 32'h0BAD_F00D;
    ph1_cnt = 0; stg_cnt = 0;
    push_run(cfg_cd, 1, 12);
    pulse_start();
    send_rt(rt_vec[0], 1'b1);
    pulse_start();
    wait_finished(400);
    check_end("partial", 1'b0, 16'd11, 12, 12);
    partial_mode = 1'b0;
  endtask

  task automatic test_budget();
    done_const = 4'h0; max_cycles = 16'd8; cfg_cd = 12'hFFF;
    rt_vec[0] = 32'h8000_0001;
    ph1_cnt = 0; stg_cnt = 0;
    push_run(cfg_cd, 1, 8);
    pulse_start();
    send_rt(rt_vec[0], 1'b1);
    wait_finished(400);
    check_end("budget", 1'b1, 16'd7, 8, 8);
    repeat (3) @(posedge clk);
    #1;
    checks = checks + 1;
    if (finished !== 1'b1 || timeout !== 1'b1 || bus.in_cycle !== 16'd7) begin
      errors = errors + 1;
      $display("FAIL finish_hold got fin=%b to=%b cyc=%0d required 1/1/7", finished, timeout, bus.in_cycle);
    end
  endtask

  task automatic test_back_to_back();
    done_const = 4'hF; max_cycles = 16'd0; cfg_cd = 12'd3;
    rt_vec[0] = 32'h0000_00FF;
    ph1_cnt = 0; stg_cnt = 0;
    push_run(cfg_cd, 1, 2);
    pulse_start();
    checks = checks + 1;
    if (timeout !== 1'b0 || busy !== 1'b1 || finished !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL restart got to=%b busy=%b fin=%b required 0/1/0", timeout, busy, finished);
    end
    send_rt(rt_vec[0], 1'b1);
    wait_finished(200);
    check_end("b2b", 1'b0, 16'd1, 2, 2);
  endtask

`ifdef SEQ_STEP_MODE_EN
  task automatic test_step_mode();
    int n;
    done_const = 4'h0; max_cycles = 16'd3; cfg_cd = 12'd9;
    rt_vec[0] = 32'h5555_AAAA;
    ph1_cnt = 0; stg_cnt = 0;
    push_run(cfg_cd, 1, 3);
    pulse_start();
    send_rt(rt_vec[0], 1'b1);
    for (int s = 1; s <= 2; s++) begin
      n = 0;
      while (ph1_cnt < s && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      repeat (8) @(negedge clk);
      checks = checks + 1;
      if (bus.op !== OP_NOP || bus.in_cycle !== 16'(s) || ph1_cnt != s || busy !== 1'b1) begin
        errors = errors + 1;
        $display("FAIL hold_%0d got op=%0d cyc=%0d ph1=%0d busy=%b required 0/%0d/%0d/1",
                 s, bus.op, bus.in_cycle, ph1_cnt, busy, s, s);
      end
      @(posedge clk); #1 step_req = 1'b1;
      @(posedge clk); #1 step_req = 1'b0;
    end
    wait_finished(100);
    check_end("step", 1'b1, 16'd2, 3, 3);
  endtask
`endif

  initial begin
    bus.rt_valid = 1'b0;
    bus.rt_data  = '0;
    bus.rt_last  = 1'b0;
    test_reset();
    test_bringup_quiesce();
    test_partial_done();
    test_budget();
    test_back_to_back();
`ifdef SEQ_STEP_MODE_EN
    test_step_mode();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
